// File: rtl/tcb_infer_sched.sv
// Round-robin scheduler sharing one TCB 121-32-10 inference network
// between two requesters, with a watchdog on the network done pulse.
module tcb_infer_sched #(
  parameter int IMG_W   = 968,
  parameter int NUM_W   = 32,
  parameter int TIMEOUT = 4096,
  parameter int TMR_W   = 13
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic [IMG_W-1:0] req0_img,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [IMG_W-1:0] req1_img,
  output logic             req1_ready,
  output logic [IMG_W-1:0] net_img,
  output logic             net_valid,
  input  logic             net_ready,
  input  logic [NUM_W-1:0] net_number,
  output logic             res_valid,
  output logic             res_id,
  output logic [NUM_W-1:0] res_number,
  output logic             res_timeout,
  input  logic             res_ack,
  output logic             busy,
  output logic [15:0]      done_cnt,
  output logic [7:0]       to_cnt
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT,
    S_DONE
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic             last_served;
  logic [TMR_W-1:0] timer;
  logic             grant0;
  logic             grant1;

  // Contention goes to whoever was not served last.
  assign grant0 = req0_valid & (~req1_valid | last_served);
  assign grant1 = req1_valid & (~req0_valid | ~last_served);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:   if (grant0 | grant1) state_nx = S_LAUNCH;
      S_LAUNCH: state_nx = S_WAIT;
      S_WAIT:   if (net_ready || timer == '0) state_nx = S_DONE;
      S_DONE:   if (res_ack) state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    net_valid  = 1'b0;
    res_valid  = 1'b0;
    busy       = (state != S_IDLE);
    case (state)
      S_IDLE: begin
        req0_ready = ~rst & grant0;
        req1_ready = ~rst & grant1;
      end
      S_LAUNCH: net_valid = 1'b1;
      S_DONE:   res_valid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      net_img     <= '0;
      res_id      <= 1'b0;
      last_served <= 1'b1;
      timer       <= '0;
      res_number  <= '0;
      res_timeout <= 1'b0;
      done_cnt    <= '0;
      to_cnt      <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (grant0 | grant1) begin
            net_img     <= grant0 ? req0_img : req1_img;
            res_id      <= grant1;
            last_served <= grant1;
          end
        end
        S_LAUNCH: timer <= TMR_W'(TIMEOUT - 1);
        S_WAIT: begin
          // A done pulse on the last timer cycle still wins.
          if (net_ready) begin
            res_number  <= net_number;
            res_timeout <= 1'b0;
          end else if (timer == '0) begin
            res_number  <= '0;
            res_timeout <= 1'b1;
          end else begin
            timer <= timer - 1'b1;
          end
        end
        S_DONE: begin
          if (res_ack) begin
            if (!res_timeout)       done_cnt <= done_cnt + 16'd1;
            else if (to_cnt != '1)  to_cnt   <= to_cnt + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_tcb_infer_sched.sv
// Bench for tcb_infer_sched: directed and random jobs checked
// against a transaction-level model of arbitration and counters.
module tb_tcb_infer_sched;

  localparam int IMG_W = 968;
  localparam int NUM_W = 32;
  localparam int TO    = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             req0_valid = 1'b0;
  logic [IMG_W-1:0] req0_img = '0;
  logic             req0_ready;
  logic             req1_valid = 1'b0;
  logic [IMG_W-1:0] req1_img = '0;
  logic             req1_ready;
  logic [IMG_W-1:0] net_img;
  logic             net_valid;
  logic             net_ready = 1'b0;
  logic [NUM_W-1:0] net_number = '0;
  logic             res_valid;
  logic             res_id;
  logic [NUM_W-1:0] res_number;
  logic             res_timeout;
  logic             res_ack = 1'b0;
  logic             busy;
  logic [15:0]      done_cnt;
  logic [7:0]       to_cnt;

  tcb_infer_sched #(
    .IMG_W(IMG_W), .NUM_W(NUM_W), .TIMEOUT(TO), .TMR_W(5)
  ) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_img(req0_img), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_img(req1_img), .req1_ready(req1_ready),
    .net_img(net_img), .net_valid(net_valid),
    .net_ready(net_ready), .net_number(net_number),
    .res_valid(res_valid), .res_id(res_id), .res_number(res_number),
    .res_timeout(res_timeout), .res_ack(res_ack), .busy(busy),
    .done_cnt(done_cnt), .to_cnt(to_cnt)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Model: who was served last, completed/aborted counts, last result.
  int          m_last = 1;
  int          m_done = 0;
  int          m_to   = 0;
  logic [31:0] m_num  = '0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  function automatic logic [IMG_W-1:0] rimg();
    logic [IMG_W-1:0] r;
    r = '0;
    for (int i = 0; i < IMG_W / 8; i++) r[i*8 +: 8] = 8'($urandom);
    return r;
  endfunction

  task automatic job(input bit v0, input bit v1, input int lat,
                     input bit respond, input int hold, input bit stray);
    logic [IMG_W-1:0] i0, i1, eimg;
    logic [31:0]      num, en;
    int               win, n;
    i0 = rimg();
    i1 = rimg();
    req0_valid = v0; req0_img = i0;
    req1_valid = v1; req1_img = i1;
    win  = (v0 && v1) ? ((m_last == 1) ? 0 : 1) : (v0 ? 0 : 1);
    eimg = (win == 0) ? i0 : i1;
    #1;
    chk("ready0", req0_ready, 32'(win == 0));
    chk("ready1", req1_ready, 32'(win == 1));
    m_last = win;
    net_ready = stray;
    net_number = $urandom;
    step();
    chk("launch_pulse", net_valid, 1);
    chk("net_img", 32'(net_img === eimg), 1);
    chk("res_id_launch", res_id, win);
    chk("ready_launch", req0_ready | req1_ready, 0);
    net_ready = 1'b0;
    num = $urandom;
    n = 0;
    step();
    while (!res_valid && n < TO + 4) begin
      n++;
      chk("no_pulse_wait", net_valid, 0);
      if (respond && n == lat) begin
        net_ready = 1'b1; net_number = num;
      end else begin
        net_ready = 1'b0; net_number = $urandom;
      end
      step();
    end
    net_ready = 1'b0;
    chk("wait_cycles", n, respond ? lat : TO);
    en = respond ? num : 32'd0;
    for (int h = 0; h <= hold; h++) begin
      chk("res_valid", res_valid, 1);
      chk("res_id", res_id, win);
      chk("res_number", res_number, en);
      chk("res_timeout", res_timeout, 32'(!respond));
      chk("ready_done", req0_ready | req1_ready, 0);
      chk("busy_done", busy, 1);
      net_ready  = stray && (h % 2 == 0);
      net_number = $urandom;
      res_ack    = (h == hold);
      step();
    end
    res_ack = 1'b0; net_ready = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    if (respond) m_done = (m_done + 1) % 65536;
    else if (m_to < 255) m_to++;
    m_num = en;
    chk("res_valid_drop", res_valid, 0);
    chk("busy_idle", busy, 0);
    chk("done_cnt", done_cnt, m_done);
    chk("to_cnt", to_cnt, m_to);
    chk("res_number_kept", res_number, m_num);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_img"}, 32'(net_img == '0), 1);
    chk({tag, "_outs"}, {net_valid, res_valid, res_id, res_timeout,
                         busy, req0_ready, req1_ready}, 0);
    chk({tag, "_num"}, res_number, 0);
    chk({tag, "_cnt"}, {done_cnt, to_cnt}, 0);
  endtask

  initial begin
    rst = 1'b1;
    req0_valid = 1'b1; req1_valid = 1'b1;
    step();
    chk_zero("reset");
    req0_valid = 1'b0; req1_valid = 1'b0;
    rst = 1'b0;
    step();

    job(1, 0, 10, 1, 0, 0);
    for (int k = 0; k < 4; k++) job(1, 1, 5, 1, 0, 0);
    job(0, 1, 0, 0, 0, 0);
    job(1, 0, TO, 1, 0, 1);
    job(1, 1, 1, 1, 0, 1);

    net_ready = 1'b1; net_number = $urandom;
    step();
    net_ready = 1'b0;
    chk("stray_idle_busy", busy, 0);
    chk("stray_idle_valid", res_valid, 0);
    chk("stray_idle_num", res_number, m_num);

    job(1, 1, 3, 1, 50, 0);

    for (int k = 0; k < 12; k++) begin
      int  sel;
      sel = $urandom_range(1, 3);
      job(sel[0], sel[1], $urandom_range(1, TO),
          ($urandom_range(0, 3) != 0), $urandom_range(0, 3),
          1'($urandom_range(0, 1)));
    end

    while (m_to < 255) job(1, 1, 0, 0, 0, 0);
    job(0, 1, 0, 0, 0, 0);

    req0_valid = 1'b1;
    step();
    req0_valid = 1'b0;
    step();
    step();
    step();
    chk("pre_reset_busy", busy, 1);
    rst = 1'b1;
    #1;
    chk_zero("mid_reset");
    m_last = 1; m_done = 0; m_to = 0; m_num = '0;
    step();
    rst = 1'b0;
    job(1, 1, 4, 1, 0, 0);
    job(1, 1, 4, 1, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout tests=%0d", tests);
    $fatal(1, "bench time limit");
  end

endmodule

// File: doc/tcb_infer_sched.md
Name: tcb_infer_sched

Overview:
- Two-requester scheduler for the TCB 121-32-10 inference pipeline (layer0 -> layer2 -> comparator).
- Grants the single network instance to one requester at a time, round-robin.
- Latches the winning image onto the network input and issues the start pulse.
- Waits for the done pulse under a watchdog, then holds the prediction and requester ID until it is acknowledged.

Parameters:
- IMG_W, 968, image bus width (121 pixels x 8 bit).
- NUM_W, 32, prediction width.
- TIMEOUT, 4096, max cycles in WAIT before abort; must exceed worst-case network latency; must be >= 2.
- TMR_W, 13, timer width; must satisfy 2^TMR_W > TIMEOUT.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- req0_valid  in  1  requester 0 has an image.
- req0_img  in  IMG_W  requester 0 image.
- req0_ready  out  1  requester 0 accept; transfer when valid & ready.
- req1_valid  in  1  requester 1 has an image.
- req1_img  in  IMG_W  requester 1 image.
- req1_ready  out  1  requester 1 accept.
- net_img  out  IMG_W  registered image to network.
- net_valid  out  1  one-cycle start pulse to network.
- net_ready  in  1  one-cycle done pulse from network.
- net_number  in  NUM_W  prediction, valid with net_ready.
- res_valid  out  1  result held until acked.
- res_id  out  1  requester that owns the result.
- res_number  out  NUM_W  prediction; 0 on timeout.
- res_timeout  out  1  result was aborted by watchdog.
- res_ack  in  1  result consumed.
- busy  out  1  state != IDLE.
- done_cnt  out  16  completed (non-timeout) results acked; wraps 0xFFFF -> 0.
- to_cnt  out  8  timeouts acked; saturates at 255.

Behaviour:
- Reset (async, immediate): all outputs 0, state IDLE, timer 0, last_served = 1 so requester 0 wins first.
- States: IDLE, LAUNCH, WAIT, DONE.
- IDLE, arbitration: reqN_ready is combinational = (state == IDLE) & grantN.
  - If both request, grant the requester != last_served.
  - If one requests, it wins.
  - Acceptance cycle: register img into net_img, id into res_id and last_served; go to LAUNCH.
  - No request: stay in IDLE, both ready = 0.
- LAUNCH (1 cycle):
  - net_valid = 1; load timer = TIMEOUT - 1; go to WAIT.
  - net_ready in this cycle is ignored.
- WAIT:
  - net_ready = 1: register net_number into res_number, res_timeout = 0, go to DONE.
  - Otherwise, timer = 0: res_number = 0, res_timeout = 1, go to DONE.
  - Otherwise decrement timer.
  - net_ready on the same cycle the timer reaches 0 counts as success.
- DONE:
  - res_valid = 1; res_id, res_number and res_timeout held stable.
  - On res_ack: update the counter (done_cnt +1 if !res_timeout, else to_cnt +1 saturating), res_valid drops next cycle, go to IDLE.
  - Next arbitration earliest the cycle after return to IDLE, so there is no grant in the ack cycle.
- net_ready outside WAIT is ignored. net_img holds its value until the next acceptance.
- net_valid is never high outside LAUNCH.
- Latency: accept at cycle T -> net_valid at T+1 -> WAIT from T+2. A network done at cycle T+1+L gives res_valid from T+2+L.
- Reset asserted mid-operation: everything returns to reset values immediately, the in-flight result is discarded, and no counter is updated.
- res_ack outside DONE is ignored.
- reqN_img need only be valid in the acceptance cycle.

Test Plan:
- Single job: req0_valid=1, img=pattern A; network returns net_number=7 after 20 cycles -> net_valid pulse 1 cycle after accept; res_valid with res_id=0, res_number=7, res_timeout=0; after ack done_cnt=1.
- Contention: both valid continuously, network done after 5 cycles, immediate ack -> grants 0,1,0,1; net_img matches each owner's image; never two grants in a row to one requester.
- Watchdog: TIMEOUT=16, network never responds -> exactly 16 WAIT cycles, then res_valid with res_timeout=1, res_number=0; after ack to_cnt=1, done_cnt unchanged.
- Boundary and stray pulses: net_ready on the final timer cycle -> success with the captured number. net_ready pulses in IDLE, LAUNCH and DONE -> no state change and res_number unchanged.
- Backpressure: hold res_ack=0 for 50 cycles with both requesters valid -> result stable, req0_ready/req1_ready stay 0, busy=1.
- Reset: assert rst during WAIT -> outputs 0 the same cycle. After release, req1 and req0 both valid -> req0 granted first.
